// File: rtl/p_multdiv.sv
// Iterative signed multiply/divide unit beside the execute-stage ALU.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module p_multdiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH:0]   amag_q, amag_d;
  logic [WIDTH:0]   bmag_q, bmag_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   a_ext, b_ext, mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next, prod_s;
  logic             mul_ovf;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] quo_mag, quo_s;
  logic             quo_neg;
  logic             last;

  // Magnitudes kept one bit wider so |-2^(WIDTH-1)| is exact
  assign a_ext = {data_operandA[WIDTH-1], data_operandA};
  assign b_ext = {data_operandB[WIDTH-1], data_operandB};
  assign mag_a = a_ext[WIDTH] ? -a_ext : a_ext;
  assign mag_b = b_ext[WIDTH] ? -b_ext : b_ext;

  // Multiply step: acc holds {partial high, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? amag_q : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_s   = neg_q ? -mul_next : mul_next;
  assign mul_ovf  = !((&prod_s[PW-1:WIDTH-1]) || !(|prod_s[PW-1:WIDTH-1]));

  // Divide step: acc low half shifts dividend out and quotient bits in
  assign rem_sh  = {rem_q, acc_q[WIDTH-1]};
  assign div_ge  = rem_sh >= bmag_q;
  assign quo_mag = {acc_q[WIDTH-2:0], div_ge};
  assign quo_neg = neg_q && (quo_mag != '0);
  assign quo_s   = quo_neg ? -quo_mag : quo_mag;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      amag_q  <= '0;
      bmag_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      amag_q  <= amag_d;
      bmag_q  <= bmag_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    amag_d  = amag_q;
    bmag_d  = bmag_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          neg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          amag_d = mag_a;
          bmag_d = mag_b;
          cnt_d  = '0;
          rem_d  = '0;
          if (ctrl_MULT) begin
            acc_d   = {{WIDTH{1'b0}}, mag_b[WIDTH-1:0]};
            state_d = MUL;
            busy_d  = 1'b1;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_a[WIDTH-1:0]};
            if (data_operandB == '0) begin
              state_d = DONE;
              res_d   = '0;
              exc_d   = 1'b1;
              rdy_d   = 1'b1;
            end else begin
              state_d = DIV;
              busy_d  = 1'b1;
            end
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
          res_d   = prod_s[WIDTH-1:0];
          exc_d   = mul_ovf;
          rdy_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DIV: begin
        acc_d = {acc_q[PW-1:WIDTH], quo_mag};
        rem_d = div_ge ? WIDTH'(rem_sh - bmag_q) : rem_sh[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
          res_d   = quo_s;
          exc_d   = !quo_neg && quo_mag[WIDTH-1];
          rdy_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign data_busy      = busy_q;

endmodule

// File: tb/tb_p_multdiv.sv
// Bench for p_multdiv: directed and random mul/div against an arithmetic reference model.
module tb_p_multdiv;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, data_busy;

  int ncmp = 0;
  int nerr = 0;

  p_multdiv dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .data_busy     (data_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, SV division truncates toward zero
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e, output int lat);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    lat = 33;
    if (is_mul) begin
      p = pa * pb;
      r = 32'(p);
      e = (p > longint'(2147483647)) || (p < -longint'(2147483647) - 1);
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
      lat = 1;
    end else begin
      p = pa / pb;
      r = 32'(p);
      e = (p > longint'(2147483647));
    end
  endfunction

  // Start at a negedge (cycle 0), then walk cycles checking busy, latency and result
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    logic [31:0] er;
    bit          ee;
    int          lat;
    bit          seen;
    model(m, a, b, er, ee, lat);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      chk("busy", 32'(data_busy), 32'(cyc < lat));
      if (data_resultRDY) begin
        seen = 1'b1;
        chk("latency", 32'(cyc), 32'(lat));
        chk("result", data_result, er);
        chk("exception", 32'(data_exception), 32'(ee));
        break;
      end
      if (disturb && cyc == 5) begin
        ctrl_DIV = 1'b1;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
      if (disturb && cyc == 6) ctrl_DIV = 1'b0;
      @(negedge clock);
    end
    if (!seen) chk("rdy_timeout", 32'(data_resultRDY), 32'h1);
    @(negedge clock);
    chk("rdy_pulse_end", 32'(data_resultRDY), 32'h0);
    chk("busy_after", 32'(data_busy), 32'h0);
  endtask

  function automatic logic [31:0] pick();
    int unsigned sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($signed($urandom_range(0, 200)) - 100);
      4: return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit any_rdy;
    logic [31:0] ra, rb;
    bit rm;
    ctrl_reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 32'h0);
    chk("rst_exc", 32'(data_exception), 32'h0);
    chk("rst_rdy", 32'(data_resultRDY), 32'h0);
    chk("rst_busy", 32'(data_busy), 32'h0);
    ctrl_reset = 1'b1;
    @(negedge clock);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b0);
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 1'b1, 32'd123, 32'd0, 1'b0);
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 1'b1);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'd1, 1'b0);
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFF8, 1'b0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 1'b0);

    // Abort a multiply with reset in cycle 10
    ctrl_MULT = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    ctrl_reset = 1'b0;
    @(negedge clock);
    chk("abort_result", data_result, 32'h0);
    chk("abort_exc", 32'(data_exception), 32'h0);
    chk("abort_rdy", 32'(data_resultRDY), 32'h0);
    chk("abort_busy", 32'(data_busy), 32'h0);
    ctrl_reset = 1'b1;
    any_rdy = 1'b0;
    repeat (30) begin
      @(negedge clock);
      any_rdy |= data_resultRDY;
    end
    chk("abort_no_rdy", 32'(any_rdy), 32'h0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      rm = 1'($urandom_range(0, 1));
      run_op(rm, !rm, ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/p_multdiv.md
Name: p_multdiv

Overview:
- Iterative signed 32-bit multiply/divide unit.
- Sits in the execute stage beside p_alu and shares its operand buses, data_operandA and data_operandB.
- Handles mul/div instructions that the single-cycle ALU cannot. The pipeline stalls on data_busy until data_resultRDY, then writes data_result back through the same writeback path as ALU results.

Parameters:
- WIDTH, 32, operand and result width; all counts below are given for WIDTH=32.
- CNT_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- ctrl_reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
- data_operandA  input  32  multiplicand / dividend, signed two's complement.
- data_operandB  input  32  multiplier / divisor, signed two's complement.
- ctrl_MULT  input  1  start a multiply; single-cycle pulse.
- ctrl_DIV  input  1  start a divide; single-cycle pulse.
- data_result  output  32  signed product (low 32 bits) or quotient.
- data_exception  output  1  result not valid: overflow or divide-by-zero; qualified by data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse marking data_result and data_exception as valid.
- data_busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (ctrl_reset=0 at a clock edge):
  - State goes to IDLE; counter, accumulator and operand registers clear.
  - data_result=0, data_exception=0, data_resultRDY=0, data_busy=0.
  - Reset mid-operation aborts the operation; no RDY pulse is produced for it.
- States are IDLE, MUL, DIV, DONE.
- IDLE:
  - A start is accepted in the cycle where ctrl_MULT or ctrl_DIV is high; call that cycle 0.
  - On acceptance, both operands are latched and their signs and magnitudes are recorded.
  - If ctrl_MULT and ctrl_DIV are both high, the multiply wins.
  - Start pulses are ignored in every state other than IDLE; later operand changes do not affect an accepted operation.
- MUL:
  - Unsigned radix-2 shift-add on the magnitudes, one multiplier bit per cycle, 32 iterations in cycles 1..32.
  - The full 64-bit magnitude product is kept.
- DIV:
  - Restoring division on the magnitudes, one quotient bit per cycle, 32 iterations in cycles 1..32.
  - Divisor of 0: skip the iterations and go straight to DONE in cycle 1.
- Move to DONE after the 32nd iteration.
- data_busy is high from cycle 1 until the cycle before DONE completes.
- DONE (one cycle):
  - data_resultRDY=1 and data_result/data_exception are driven.
  - Return to IDLE on the next edge.
  - A new start can be accepted in the cycle after DONE.
  - Latency: RDY in cycle 33 for a normal operation, cycle 1 for divide-by-zero.
- data_result and data_exception hold their last values until the next DONE; they are meaningful only when RDY is high.
- Sign and exception rules:
  - Product sign is signA XOR signB; the 64-bit result is negated if the sign is negative.
  - Multiply: data_result = low 32 bits of the signed product. data_exception=1 if the signed 64-bit product is outside [-2^31, 2^31-1], i.e. bits 63..31 are not all equal.
  - Divide: quotient truncates toward zero and the remainder is discarded. Quotient sign is signA XOR signB, and is positive when the quotient is 0.
  - Divide by 0: data_result=0, data_exception=1.
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
  - All other divides: data_exception=0.
- Magnitudes are computed 33 bits wide, so the magnitude of -2^31 is represented correctly.

Test Plan:
- Reset, then ctrl_MULT with A=7, B=-6 -> data_busy high in cycles 1..32; RDY only in cycle 33; data_result=0xFFFFFFD6 (-42); exception=0.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Then A=0xFFFFFFFF, B=0x80000000 -> result=0x80000000, exception=1.
- ctrl_DIV with A=-7, B=2 -> result=-3 (0xFFFFFFFD), exception=0, RDY in cycle 33. Then A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_DIV with A=123, B=0 -> RDY in cycle 1, result=0, exception=1, data_busy never asserted.
- ctrl_MULT and ctrl_DIV together with A=3, B=4 -> result=12. While busy: a second ctrl_DIV pulse and changes to the operands -> ignored, result is still 12. A start in the cycle after RDY is accepted.
- Start ctrl_MULT with A=5, B=5; assert ctrl_reset=0 in cycle 10 -> all outputs 0 the next cycle, no RDY pulse. After release, ctrl_DIV with A=100, B=7 -> result=14.
